dram_cmd_scheduler: RTL and testbench

In-order DRAM command scheduler. It drives the `commands`/`bg`/`ba` inputs of `TimingFSM` and of the bank models from the controller side.

- Accepts one read or write request at a time on a valid/ready handshake.
- Tracks the open row of every bank.
- Issues PR/ACT/RD/RDA/WR/WRA with the same tRCD/tRP/tWR/BL spacing that `TimingFSM` enforces.
- Inserts periodic all-bank refresh.

---
 rtl/dram_cmd_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// ============================================================================
// Module   : dram_cmd_scheduler
// Purpose  : In-order DRAM command scheduler with open-row tracking and
//            periodic all-bank refresh.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_cmd_scheduler #(
  parameter int BGWIDTH    = 2,
  parameter int BANKGROUPS = 2**BGWIDTH,
  parameter int BAWIDTH    = 2,
  parameter int ROWWIDTH   = 16,
  parameter int BL         = 8,
  parameter int T_RCD      = 17,
  parameter int T_RP       = 17,
  parameter int T_WR       = 14,
  parameter int T_RFC      = 34,
  parameter int T_REFI     = 7800
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_autopre,
  input  logic [BGWIDTH-1:0]  req_bg,
  input  logic [BAWIDTH-1:0]  req_ba,
  input  logic [ROWWIDTH-1:0] req_row,
  output logic                req_done,
  output logic [18:0]         commands,
  output logic [BGWIDTH-1:0]  bg,
  output logic [BAWIDTH-1:0]  ba,
  output logic [ROWWIDTH-1:0] row
);

  localparam int BANKSPERGROUP = 2**BAWIDTH;
  localparam int c_nbanks      = BANKGROUPS * BANKSPERGROUP;
  localparam int c_idxw        = BGWIDTH + BAWIDTH;

  localparam int c_max_a = (T_REFI > T_RFC) ? T_REFI : T_RFC;
  localparam int c_max_b = ((T_WR + T_RP) > (BL + T_RP)) ? (T_WR + T_RP) : (BL + T_RP);
  localparam int c_max   = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cntw  = $clog2(c_max + 1);

  localparam logic [c_cntw-1:0] c_refi_reload = c_cntw'(T_REFI - 1);
  localparam logic [c_cntw-1:0] c_wait_rp     = c_cntw'(T_RP - 2);
  localparam logic [c_cntw-1:0] c_wait_rcd    = c_cntw'(T_RCD - 2);
  localparam logic [c_cntw-1:0] c_wait_rfc    = c_cntw'(T_RFC - 1);
  localparam logic [c_cntw-1:0] c_wait_rd     = c_cntw'(BL - 1);
  localparam logic [c_cntw-1:0] c_wait_rda    = c_cntw'(BL + T_RP - 1);
  localparam logic [c_cntw-1:0] c_wait_wr     = c_cntw'(T_WR - 1);
  localparam logic [c_cntw-1:0] c_wait_wra    = c_cntw'(T_WR + T_RP - 1);

  localparam int c_cmd_act = 18;
  localparam int c_cmd_pr  = 7;
  localparam int c_cmd_pra = 6;
  localparam int c_cmd_rd  = 5;
  localparam int c_cmd_rda = 4;
  localparam int c_cmd_ref = 3;
  localparam int c_cmd_wr  = 1;
  localparam int c_cmd_wra = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_COL,
    ST_WAIT_COL,
    ST_REF_PRA,
    ST_WAIT_RP_REF,
    ST_REF,
    ST_WAIT_RFC
  } state_t;

  state_t                r_state;
  logic [c_cntw-1:0]     r_cnt;
  logic [c_cntw-1:0]     r_refi_cnt;
  logic                  r_ref_pending;
  logic [c_nbanks-1:0]   r_open_vld;
  logic [ROWWIDTH-1:0]   r_open_row [c_nbanks];
  logic                  r_req_write;
  logic                  r_req_autopre;
  logic [BGWIDTH-1:0]    r_req_bg;
  logic [BAWIDTH-1:0]    r_req_ba;
  logic [ROWWIDTH-1:0]   r_req_row;
  logic [18:0]           r_commands;
  logic [BGWIDTH-1:0]    r_cmd_bg;
  logic [BAWIDTH-1:0]    r_cmd_ba;
  logic [ROWWIDTH-1:0]   r_cmd_row;
  logic                  r_req_done;

  logic [c_idxw-1:0]     w_idx;
  logic                  w_row_hit;
  logic                  w_any_open;
  logic [c_cntw-1:0]     w_col_wait;

  assign w_idx      = {r_req_bg, r_req_ba};
  assign w_row_hit  = r_open_vld[w_idx] && (r_open_row[w_idx] == r_req_row);
  assign w_any_open = |r_open_vld;

  always_comb begin
    w_col_wait = c_wait_rd;
    case ({r_req_write, r_req_autopre})
      2'b00:   w_col_wait = c_wait_rd;
      2'b01:   w_col_wait = c_wait_rda;
      2'b10:   w_col_wait = c_wait_wr;
      default: w_col_wait = c_wait_wra;
    endcase
  end

  // Gated by reset_n so the handshake is closed for the whole reset window.
  assign req_ready = reset_n && (r_state == ST_IDLE) && !r_ref_pending;
  assign req_done  = r_req_done;
  assign commands  = r_commands;
  assign bg        = r_cmd_bg;
  assign ba        = r_cmd_ba;
  assign row       = r_cmd_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_refi_cnt    <= c_refi_reload;
      r_ref_pending <= 1'b0;
      r_open_vld    <= '0;
      for (int i = 0; i < c_nbanks; i++) begin
        r_open_row[i] <= '0;
      end
      r_req_write   <= 1'b0;
      r_req_autopre <= 1'b0;
      r_req_bg      <= '0;
      r_req_ba      <= '0;
      r_req_row     <= '0;
      r_commands    <= '0;
      r_cmd_bg      <= '0;
      r_cmd_ba      <= '0;
      r_cmd_row     <= '0;
      r_req_done    <= 1'b0;
    end else begin
      r_commands <= '0;
      r_cmd_bg   <= '0;
      r_cmd_ba   <= '0;
      r_cmd_row  <= '0;
      r_req_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_ref_pending) begin
            r_state <= w_any_open ? ST_REF_PRA : ST_REF;
          end else if (req_valid) begin
            r_req_write   <= req_write;
            r_req_autopre <= req_autopre;
            r_req_bg      <= req_bg;
            r_req_ba      <= req_ba;
            r_req_row     <= req_row;
            r_state       <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (w_row_hit) begin
            r_state <= ST_COL;
          end else if (!r_open_vld[w_idx]) begin
            r_state <= ST_ACT;
          end else begin
            r_state <= ST_PRE;
          end
        end
        ST_PRE: begin
          r_commands[c_cmd_pr] <= 1'b1;
          r_cmd_bg             <= r_req_bg;
          r_cmd_ba             <= r_req_ba;
          r_open_vld[w_idx]    <= 1'b0;
          r_cnt                <= c_wait_rp;
          r_state              <= ST_WAIT_RP;
        end
        ST_WAIT_RP: begin
          if (r_cnt == '0) r_state <= ST_ACT;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_ACT: begin
          r_commands[c_cmd_act] <= 1'b1;
          r_cmd_bg              <= r_req_bg;
          r_cmd_ba              <= r_req_ba;
          r_cmd_row             <= r_req_row;
          r_open_vld[w_idx]     <= 1'b1;
          r_open_row[w_idx]     <= r_req_row;
          r_cnt                 <= c_wait_rcd;
          r_state               <= ST_WAIT_RCD;
        end
        ST_WAIT_RCD: begin
          if (r_cnt == '0) r_state <= ST_COL;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_COL: begin
          if (r_req_write) begin
            if (r_req_autopre) r_commands[c_cmd_wra] <= 1'b1;
            else               r_commands[c_cmd_wr]  <= 1'b1;
          end else begin
            if (r_req_autopre) r_commands[c_cmd_rda] <= 1'b1;
            else               r_commands[c_cmd_rd]  <= 1'b1;
          end
          r_cmd_bg <= r_req_bg;
          r_cmd_ba <= r_req_ba;
          r_cnt    <= w_col_wait;
          r_state  <= ST_WAIT_COL;
        end
        ST_WAIT_COL: begin
          if (r_cnt == '0) begin
            r_req_done <= 1'b1;
            // Autoprecharge closes the bank once its precharge time has elapsed.
            if (r_req_autopre) r_open_vld[w_idx] <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_REF_PRA: begin
          r_commands[c_cmd_pra] <= 1'b1;
          r_open_vld            <= '0;
          r_cnt                 <= c_wait_rp;
          r_state               <= ST_WAIT_RP_REF;
        end
        ST_WAIT_RP_REF: begin
          if (r_cnt == '0) r_state <= ST_REF;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_REF: begin
          r_commands[c_cmd_ref] <= 1'b1;
          r_ref_pending         <= 1'b0;
          r_cnt                 <= c_wait_rfc;
          r_state               <= ST_WAIT_RFC;
        end
        ST_WAIT_RFC: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Placed after the FSM so a fresh expiry wins over a same-cycle REF clear.
      if (r_refi_cnt == '0) begin
        r_refi_cnt    <= c_refi_reload;
        r_ref_pending <= 1'b1;
      end else begin
        r_refi_cnt <= r_refi_cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_cmd_scheduler.sv
// ============================================================================
// Module   : tb_dram_cmd_scheduler
// Purpose  : Directed self-checking bench for dram_cmd_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_cmd_scheduler;

  localparam int BGWIDTH  = 2;
  localparam int BAWIDTH  = 2;
  localparam int ROWWIDTH = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic                req_autopre;
  logic [BGWIDTH-1:0]  req_bg;
  logic [BAWIDTH-1:0]  req_ba;
  logic [ROWWIDTH-1:0] req_row;
  logic                req_done;
  logic [18:0]         commands;
  logic [BGWIDTH-1:0]  bg;
  logic [BAWIDTH-1:0]  ba;
  logic [ROWWIDTH-1:0] row;

  dram_cmd_scheduler #(
    .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ROWWIDTH(ROWWIDTH),
    .BL(8), .T_RCD(17), .T_RP(17), .T_WR(14), .T_RFC(34), .T_REFI(200)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_autopre(req_autopre),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_done(req_done), .commands(commands),
    .bg(bg), .ba(ba), .row(row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  int t_act, t_pr, t_pra, t_ref, t_col, t_done;
  int n_act, n_pr, n_col;
  int act_ba, act_bg, act_row, col_cmd;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    t_act = -1; t_pr = -1; t_pra = -1; t_ref = -1; t_col = -1; t_done = -1;
    n_act = 0; n_pr = 0; n_col = 0;
    act_ba = -1; act_bg = -1; act_row = -1; col_cmd = -1;
  endtask

  // Advance to the next falling edge and log what the DUT shows there.
  task automatic step();
    @(negedge clk);
    if (commands[18]) begin
      if (t_act < 0) t_act = cyc;
      n_act++;
      act_ba = int'(ba); act_bg = int'(bg); act_row = int'(row);
    end
    if (commands[7]) begin
      if (t_pr < 0) t_pr = cyc;
      n_pr++;
    end
    if (commands[6] && t_pra < 0) t_pra = cyc;
    if (commands[3] && t_ref < 0) t_ref = cyc;
    if (commands[5] || commands[4] || commands[1] || commands[0]) begin
      if (t_col < 0) begin
        t_col = cyc;
        col_cmd = int'(commands);
      end
      n_col++;
    end
    if (req_done && t_done < 0) t_done = cyc;
  endtask

  task automatic start_req(input bit wr, input bit ap, input int bgv, input int bav,
                           input int rowv, output int n_acc);
    int k;
    clear_rec();
    req_write   = wr;
    req_autopre = ap;
    req_bg      = BGWIDTH'(bgv);
    req_ba      = BAWIDTH'(bav);
    req_row     = ROWWIDTH'(rowv);
    req_valid   = 1'b1;
    k = 0;
    while (!req_ready && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) check_value("accept_timeout", 0, 1);
    n_acc = cyc + 1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic issue(input bit wr, input bit ap, input int bgv, input int bav,
                       input int rowv, output int n_acc);
    int k;
    start_req(wr, ap, bgv, bav, rowv, n_acc);
    k = 0;
    while (t_done < 0 && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check_value("done_timeout", 0, 1);
  endtask

  int n, rel, drop, k;

  initial begin
    reset_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_autopre = 1'b0;
    req_bg = '0; req_ba = '0; req_row = '0;
    clear_rec();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_commands", int'(commands), 0);
    check_value("rst_ready", int'(req_ready), 0);
    check_value("rst_done", int'(req_done), 0);
    reset_n = 1'b1;
    rel = cyc + 1;
    step();
    check_value("ready_after_release", int'(req_ready), 1);

    // Write to a closed bank: ACT, WR after tRCD, done after tWR.
    issue(1'b1, 1'b0, 0, 1, 5, n);
    check_value("wr_act_lat", t_act - n, 2);
    check_value("wr_act_ba", act_ba, 1);
    check_value("wr_act_row", act_row, 5);
    check_value("wr_col_lat", t_col - n, 19);
    check_value("wr_col_cmd", col_cmd, 32'h2);
    check_value("wr_done_lat", t_done - n, 33);

    // Row hit read.
    issue(1'b0, 1'b0, 0, 1, 5, n);
    check_value("hit_col_lat", t_col - n, 2);
    check_value("hit_col_cmd", col_cmd, 32'h20);
    check_value("hit_no_act", n_act, 0);
    check_value("hit_no_pr", n_pr, 0);
    check_value("hit_done_lat", t_done - n, 10);

    // Row conflict read.
    issue(1'b0, 1'b0, 0, 1, 9, n);
    check_value("conf_pr_lat", t_pr - n, 2);
    check_value("conf_act_lat", t_act - n, 19);
    check_value("conf_act_row", act_row, 9);
    check_value("conf_col_lat", t_col - n, 36);
    check_value("conf_done_lat", t_done - n, 44);

    // Write with autoprecharge on the open row.
    issue(1'b1, 1'b1, 0, 1, 9, n);
    check_value("wra_col_lat", t_col - n, 2);
    check_value("wra_col_cmd", col_cmd, 32'h1);
    check_value("wra_done_gap", t_done - t_col, 31);

    // Bank was closed by WRA, so the same row needs ACT rather than PR.
    issue(1'b0, 1'b0, 0, 1, 9, n);
    check_value("post_wra_no_pr", n_pr, 0);
    check_value("post_wra_act_lat", t_act - n, 2);
    check_value("post_wra_n_act", n_act, 1);

    // Refresh: counter starts at T_REFI-1 on the first edge after release.
    k = 0;
    while (req_ready && k < 300) begin
      step();
      k++;
    end
    drop = cyc;
    check_value("refi_expiry_cycle", drop - rel, 199);
    issue(1'b0, 1'b0, 0, 1, 9, n);
    check_value("ref_pra_lat", t_pra - drop, 2);
    check_value("ref_after_pra", t_ref - t_pra, 17);
    check_value("ready_after_ref", (n - 1) - t_ref, 34);
    check_value("post_ref_no_pr", n_pr, 0);
    check_value("post_ref_act_lat", t_act - n, 2);
    check_value("post_ref_act_ba", act_ba, 1);

    // Reset during WAIT_RCD drops the request and empties the open table.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    issue(1'b0, 1'b0, 0, 1, 5, n);
    check_value("pre_rst_act_lat", t_act - n, 2);
    start_req(1'b0, 1'b0, 2, 2, 3, n);
    k = 0;
    while (cyc < n + 2 && k < 10) begin
      step();
      k++;
    end
    check_value("midflight_act", int'(commands), 32'h40000);
    check_value("midflight_bg", int'(bg), 2);
    #2 reset_n = 1'b0;
    #1;
    check_value("async_rst_commands", int'(commands), 0);
    check_value("async_rst_bg", int'(bg), 0);
    check_value("async_rst_ba", int'(ba), 0);
    check_value("async_rst_row", int'(row), 0);
    check_value("async_rst_ready", int'(req_ready), 0);
    clear_rec();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (40) step();
    check_value("dropped_no_done", t_done, -1);
    check_value("dropped_no_act", n_act, 0);
    check_value("dropped_no_col", n_col, 0);
    issue(1'b0, 1'b0, 0, 1, 5, n);
    check_value("after_rst_act_lat", t_act - n, 2);
    check_value("after_rst_no_pr", n_pr, 0);
    check_value("after_rst_done_lat", t_done - n, 27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
